// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared sizing defaults for the pipelined datapath blocks
package datapath_pkg;

  localparam int DEFAULT_SIZE   = 32;
  localparam int DEFAULT_STAGES = 4;

  function automatic int slice_width(input int size, input int stages);
    return size / stages;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// rtl/adder_slice.sv - combinational W-bit adder slice with carry into and out of its MSB
module adder_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         c_msb_in
);

  logic [W:0] full;

  assign full     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign s        = full[W-1:0];
  assign cout     = full[W];
  // sum bit = a ^ b ^ carry-in, so the MSB carry-in falls out without a second adder
  assign c_msb_in = a[W-1] ^ b[W-1] ^ full[W-1];

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - STAGES-deep carry-pipelined adder/subtractor with valid/ready flow control
module pipelined_adder
  import datapath_pkg::*;
#(
  parameter int SIZE   = DEFAULT_SIZE,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] X,
  input  logic [SIZE-1:0] Y,
  input  logic            Cin,
  input  logic            sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] S,
  output logic            Cout,
  output logic            ovf,
  output logic            zero
);

  localparam int W    = slice_width(SIZE, STAGES);
  localparam int LAST = STAGES - 1;

  if (STAGES < 1 || (SIZE % STAGES) != 0) begin : g_bad_geometry
    $error("pipelined_adder: SIZE must be a non-zero multiple of STAGES");
  end

  logic [STAGES-1:0] valid_q;
  logic              carry_q   [STAGES];
  logic [SIZE-1:0]   sum_q     [STAGES];
  logic [SIZE-1:0]   x_q       [STAGES];
  logic [SIZE-1:0]   y_q       [STAGES];
  logic              ovf_q;
  logic              zero_q;

  logic              src_valid [STAGES];
  logic              src_carry [STAGES];
  logic [SIZE-1:0]   src_x     [STAGES];
  logic [SIZE-1:0]   src_y     [STAGES];
  logic [SIZE-1:0]   src_sum   [STAGES];
  logic              load_ok   [STAGES];
  logic [W-1:0]      slice_s   [STAGES];
  logic              slice_cout[STAGES];
  logic              slice_cmsb[STAGES];
  logic [SIZE-1:0]   sum_d     [STAGES];
  logic              ovf_d;
  logic              zero_d;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam logic [SIZE-1:0] SLICE_MASK = SIZE'({W{1'b1}}) << (k * W);

    // subtraction is folded in at the entry: Y is inverted once and the +1 rides in as carry
    if (k == 0) begin : g_head
      assign src_valid[k] = in_valid;
      assign src_x[k]     = X;
      assign src_y[k]     = sub ? ~Y : Y;
      assign src_carry[k] = sub | Cin;
      assign src_sum[k]   = '0;
    end else begin : g_body
      assign src_valid[k] = valid_q[k-1];
      assign src_x[k]     = x_q[k-1];
      assign src_y[k]     = y_q[k-1];
      assign src_carry[k] = carry_q[k-1];
      assign src_sum[k]   = sum_q[k-1];
    end

    // a stage can load when any stage from here to the output has a hole, or the output drains
    assign load_ok[k] = out_ready | ~(&valid_q[LAST:k]);

    adder_slice #(
      .W(W)
    ) u_slice (
      .a       (src_x[k][k*W +: W]),
      .b       (src_y[k][k*W +: W]),
      .cin     (src_carry[k]),
      .s       (slice_s[k]),
      .cout    (slice_cout[k]),
      .c_msb_in(slice_cmsb[k])
    );

    assign sum_d[k] = (src_sum[k] & ~SLICE_MASK) | (SIZE'(slice_s[k]) << (k * W));
  end

  assign ovf_d  = slice_cmsb[LAST] ^ slice_cout[LAST];
  assign zero_d = (sum_d[LAST] == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '{default: 1'b0};
      sum_q   <= '{default: '0};
      x_q     <= '{default: '0};
      y_q     <= '{default: '0};
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load_ok[k]) begin
          valid_q[k] <= src_valid[k];
          if (src_valid[k]) begin
            carry_q[k] <= slice_cout[k];
            sum_q[k]   <= sum_d[k];
            x_q[k]     <= src_x[k];
            y_q[k]     <= src_y[k];
          end
        end
      end
      if (load_ok[LAST] && src_valid[LAST]) begin
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  // operands have no consumer past the last slice
  logic unused_tail;
  assign unused_tail = ^{x_q[LAST], y_q[LAST]};

  assign in_ready  = load_ok[0];
  assign out_valid = valid_q[LAST];
  assign S         = sum_q[LAST];
  assign Cout      = carry_q[LAST];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - scoreboard bench driving three pipelined_adder geometries in lockstep
module tb_pipelined_adder;

  localparam int ND = 3;

  logic        clk;
  logic        rst_n;
  logic [2:0]  in_valid_v;
  logic [31:0] X, Y;
  logic        Cin, sub, out_ready;
  wire  [2:0]  in_ready_v, out_valid_v, cout_v, ovf_v, zero_v;
  wire  [31:0] s32;
  wire  [7:0]  s8;
  wire  [15:0] s16;

  pipelined_adder #(.SIZE(32), .STAGES(4)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .X(X), .Y(Y), .Cin(Cin), .sub(sub), .out_valid(out_valid_v[0]), .out_ready(out_ready),
    .S(s32), .Cout(cout_v[0]), .ovf(ovf_v[0]), .zero(zero_v[0]));

  pipelined_adder #(.SIZE(8), .STAGES(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .X(X[7:0]), .Y(Y[7:0]), .Cin(Cin), .sub(sub), .out_valid(out_valid_v[1]), .out_ready(out_ready),
    .S(s8), .Cout(cout_v[1]), .ovf(ovf_v[1]), .zero(zero_v[1]));

  pipelined_adder #(.SIZE(16), .STAGES(8)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .X(X[15:0]), .Y(Y[15:0]), .Cin(Cin), .sub(sub), .out_valid(out_valid_v[2]), .out_ready(out_ready),
    .S(s16), .Cout(cout_v[2]), .ovf(ovf_v[2]), .zero(zero_v[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int dsize(input int d);
    return (d == 0) ? 32 : (d == 1) ? 8 : 16;
  endfunction

  function automatic int dstages(input int d);
    return (d == 0) ? 4 : (d == 1) ? 1 : 8;
  endfunction

  // reference: {zero, ovf, cout, S} from plain wide arithmetic on a size-bit word
  function automatic logic [34:0] model(input int size, input logic [31:0] x, input logic [31:0] y,
                                        input logic c, input logic sb);
    logic [63:0] mask, xx, yy, full, s;
    logic co, ov;
    mask = (64'd1 << size) - 64'd1;
    xx   = {32'd0, x} & mask;
    yy   = (sb ? ~{32'd0, y} : {32'd0, y}) & mask;
    full = xx + yy + (sb ? 64'd1 : {63'd0, c});
    s    = full & mask;
    co   = full[size];
    ov   = (xx[size-1] == yy[size-1]) && (s[size-1] != xx[size-1]);
    return {s == 64'd0, ov, co, s[31:0]};
  endfunction

  logic [34:0] obs [ND];
  assign obs[0] = {zero_v[0], ovf_v[0], cout_v[0], s32};
  assign obs[1] = {zero_v[1], ovf_v[1], cout_v[1], 24'd0, s8};
  assign obs[2] = {zero_v[2], ovf_v[2], cout_v[2], 16'd0, s16};

  logic [34:0] exp_mem [ND][64];
  int          acc_cyc [ND][64];
  int          wr_p [ND];
  int          rd_p [ND];
  int          cyc = 0;
  bit          lat_en = 1'b0;
  bit          tog_en = 1'b0;
  int          tog_idx = 0;
  logic [3:0]  tog_pat = 4'b1001;

  initial begin
    for (int d = 0; d < ND; d++) begin
      wr_p[d] = 0;
      rd_p[d] = 0;
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (tog_en) begin
      out_ready = tog_pat[3 - (tog_idx % 4)];
      tog_idx++;
    end
  end

  // sampled mid-cycle: what is visible now is what the next rising edge will act on
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < ND; d++) begin
        if (out_valid_v[d]) begin
          check_eq($sformatf("beat_outstanding_d%0d", d), 64'(wr_p[d] != rd_p[d]), 64'd1);
          if (wr_p[d] != rd_p[d]) begin
            check_eq($sformatf("result_d%0d_beat%0d", d, rd_p[d]), 64'(obs[d]), 64'(exp_mem[d][rd_p[d] % 64]));
            if (out_ready) begin
              if (lat_en)
                check_eq($sformatf("latency_d%0d", d), 64'(cyc - acc_cyc[d][rd_p[d] % 64]), 64'(dstages(d)));
              rd_p[d]++;
            end
          end
        end
        if (in_valid_v[d] && in_ready_v[d]) begin
          exp_mem[d][wr_p[d] % 64] = model(dsize(d), X, Y, Cin, sub);
          acc_cyc[d][wr_p[d] % 64] = cyc;
          wr_p[d]++;
        end
      end
    end
  end

  task automatic send_beat(input logic [31:0] x, input logic [31:0] y, input logic c, input logic sb);
    logic [2:0] pend, acc;
    X = x; Y = y; Cin = c; sub = sb;
    pend = 3'b111;
    in_valid_v = pend;
    for (int t = 0; t < 100 && pend != 3'b000; t++) begin
      @(negedge clk);
      acc = pend & in_ready_v;
      @(posedge clk);
      #1;
      pend = pend & ~acc;
      in_valid_v = pend;
    end
    check_eq("beat_accepted_by_all", 64'(pend), 64'd0);
  endtask

  task automatic send_random();
    logic [31:0] x, y;
    x = $urandom();
    y = ($urandom_range(0, 3) == 0) ? x : $urandom();
    send_beat(x, y, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic drain();
    int pending;
    out_ready = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      pending = 0;
      for (int d = 0; d < ND; d++) pending += wr_p[d] - rd_p[d];
      if (pending == 0) break;
    end
    for (int d = 0; d < ND; d++)
      check_eq($sformatf("drained_d%0d", d), 64'(wr_p[d] - rd_p[d]), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string tag, input logic [31:0] x, input logic [31:0] y, input logic c,
                          input logic sb, input logic [31:0] es, input logic eco, input logic eov,
                          input logic ez);
    int waited;
    waited = 0;
    send_beat(x, y, c, sb);
    while (!out_valid_v[0] && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_eq({tag, "_valid"}, 64'(out_valid_v[0]), 64'd1);
    check_eq({tag, "_S"},     64'(s32),           64'(es));
    check_eq({tag, "_Cout"},  64'(cout_v[0]),     64'(eco));
    check_eq({tag, "_ovf"},   64'(ovf_v[0]),      64'(eov));
    check_eq({tag, "_zero"},  64'(zero_v[0]),     64'(ez));
    drain();
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, "_out_valid"}, 64'(out_valid_v), 64'd0);
    check_eq({tag, "_S"}, 64'({s32, s16, s8}), 64'd0);
    check_eq({tag, "_flags"}, 64'({cout_v, ovf_v, zero_v}), 64'd0);
  endtask

  initial begin
    int   t0;
    logic [2:0] seen;
    rst_n = 1'b0; in_valid_v = 3'b000; X = '0; Y = '0; Cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("in_ready_after_reset", 64'(in_ready_v), 64'd7);
    @(posedge clk);
    #1;

    lat_en = 1'b1;
    directed("carry_into_upper_half", 32'h0000FFFF, 32'h1, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0);
    directed("signed_overflow",       32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    directed("sub_equal",             32'h5,        32'h5, 1'b0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b1);
    directed("ripple_all_stages",     32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1);
    directed("sub_borrow",            32'h3,        32'h5, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);

    t0 = cyc;
    for (int i = 0; i < 20; i++) send_random();
    check_eq("one_beat_per_cycle", 64'(cyc - t0), 64'd20);
    drain();
    lat_en = 1'b0;

    tog_idx = 0;
    tog_en  = 1'b1;
    for (int i = 0; i < 10; i++) send_random();
    tog_en = 1'b0;
    drain();

    out_ready = 1'b0;
    in_valid_v = 3'b111;
    for (int i = 0; i < 4; i++) begin
      X = $urandom(); Y = $urandom(); Cin = 1'($urandom_range(0, 1)); sub = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid_v = 3'b000;
    rst_n = 1'b0;
    #1;
    check_cleared("midflight_reset");
    for (int d = 0; d < ND; d++) rd_p[d] = wr_p[d];
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 3'b000;
    repeat (12) begin
      @(negedge clk);
      seen = seen | out_valid_v;
    end
    check_eq("no_result_after_reset", 64'(seen), 64'd0);
    @(posedge clk);
    #1;
    lat_en = 1'b1;
    send_random();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=%0d exp=finished", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter SIZE, default 32, operand/result width in bits.
REQ-002 SHALL have parameter STAGES, default 4, pipeline depth; SIZE SHALL be an integer multiple of STAGES, with elaboration failure otherwise.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand beat present.
REQ-006 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-007 SHALL have port X  input  SIZE  first operand.
REQ-008 SHALL have port Y  input  SIZE  second operand.
REQ-009 SHALL have port Cin  input  1  carry-in; ignored when sub=1.
REQ-010 SHALL have port sub  input  1  0 = X+Y+Cin, 1 = X-Y (X + ~Y + 1).
REQ-011 SHALL have port out_valid  output  1  result beat present.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port S  output  SIZE  sum/difference.
REQ-014 SHALL have port Cout  output  1  carry out of MSB (for sub: 1 = no borrow).
REQ-015 SHALL have port ovf  output  1  signed two's-complement overflow.
REQ-016 SHALL have port zero  output  1  S == 0.

Function
REQ-017 Slice width W = SIZE/STAGES; stage k SHALL add bits [k*W+W-1 : k*W], taking carry from stage k-1's register (stage 0 from Cin or 1 when sub).
REQ-018 Operand bits not yet consumed and already-computed sum bits SHALL travel in per-stage registers alongside a per-stage valid bit.
REQ-019 Latency SHALL be exactly STAGES cycles from accepted beat (in_valid & in_ready) to out_valid with no back-pressure.
REQ-020 Throughput SHALL be one beat per cycle while out_ready=1.
REQ-021 Stage k SHALL advance when stage k+1 is empty or advancing; last stage advances when out_ready=1 or empty; in_ready = stage 0 empty or advancing (bubbles collapse).
REQ-022 in_ready SHALL depend combinationally on out_ready and valid bits only, never on in_valid.
REQ-023 While out_valid=1 and out_ready=0, S, Cout, ovf, zero SHALL be held stable.
REQ-024 ovf SHALL equal carry into MSB XOR carry out of MSB; Cout, ovf, zero SHALL be registered with the final stage.
REQ-025 Simultaneous accept and emit on a full pipe SHALL lose no beat and duplicate none.
REQ-026 Arithmetic SHALL wrap modulo 2^SIZE; no saturation.
REQ-027 STAGES=1 SHALL degenerate to a single registered SIZE-bit adder with latency 1.

Reset
REQ-028 rst_n low SHALL immediately clear all valid bits, out_valid=0, S=0, Cout=0, ovf=0, zero=0.
REQ-029 Reset mid-operation SHALL discard all in-flight beats; first beat after release emerges after STAGES cycles.
REQ-030 in_ready SHALL be 1 from the first edge after rst_n deasserts.

Structure
REQ-031 Shared package datapath_pkg SHALL hold the default SIZE (32) and default STAGES (4) constants.
REQ-032 One combinational sub-module adder_slice (parameter W; inputs a, b, cin; outputs s, cout, c_msb_in) SHALL be instantiated STAGES times via generate.

Verification
REQ-033 SIZE=32, STAGES=4: X=0x0000FFFF, Y=1, Cin=0, sub=0 -> after 4 cycles S=0x00010000, Cout=0, ovf=0, zero=0.
REQ-034 X=0x7FFFFFFF, Y=1, sub=0 -> S=0x80000000, ovf=1, Cout=0; X=5, Y=5, sub=1 -> S=0, zero=1, Cout=1.
REQ-035 X=0xFFFFFFFF, Y=0, Cin=1 -> S=0, Cout=1, zero=1 (carry ripples across all 4 stages).
REQ-036 Stream 10 random beats with out_ready toggling 1,0,0,1 -> results in order, each matching reference model, S held while stalled, no loss/duplication.
REQ-037 Fill pipe with 4 beats, assert rst_n=0 one cycle -> out_valid=0 immediately, none of the 4 results ever emitted.
REQ-038 Repeat REQ-033 and REQ-036 with SIZE=8, STAGES=1 and SIZE=16, STAGES=8 -> latency 1 and 8 respectively, results correct.
